// File: rtl/mfp_ahb_lite_interconnect_pkg.sv
// Shared AHB-Lite encodings, default address map and payload types for the interconnect.
package mfp_ahb_lite_interconnect_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ERR_CNT_W    = 16;
    localparam int unsigned MAX_SLAVES   = 16;
    localparam int unsigned DEF_N_SLAVES = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Slave 0 = boot ROM region, slave 1 = RAM, slave 2 = GPIO/peripherals.
    localparam logic [DEF_N_SLAVES*ADDR_W-1:0] DEF_ADDR_BASE =
        {32'h1f800000, 32'h00000000, 32'h1fc00000};
    localparam logic [DEF_N_SLAVES*ADDR_W-1:0] DEF_ADDR_MASK =
        {32'h1fc00000, 32'h10000000, 32'h1fc00000};

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              ready;
        logic              resp;
    } ahb_rsp_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_default_slave.sv
// Default slave: two-cycle AHB ERROR response for unmapped active transfers.
// MFP_AHB_LITE_INTERCONNECT_ERR_LOG_EN adds an error counter and last-error capture.
module mfp_ahb_lite_default_slave
    import mfp_ahb_lite_interconnect_pkg::*;
(
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 ds_sel,
    input  logic [1:0]           HTRANS,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP
`ifdef MFP_AHB_LITE_INTERCONNECT_ERR_LOG_EN
    ,
    input  logic [ADDR_W-1:0]    HADDR,
    input  logic                 HWRITE,
    output logic [ERR_CNT_W-1:0] ERR_COUNT,
    output logic [ADDR_W-1:0]    ERR_ADDR,
    output logic                 ERR_WRITE
`endif
);

    ds_state_t state_q;
    ds_state_t state_d;
    logic      hreadyout_d;
    logic      hresp_d;
    logic      accept_c;

    assign accept_c = ds_sel && htrans_active(HTRANS) && HREADY;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= DS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else begin
            state_q   <= state_d;
            HREADYOUT <= hreadyout_d;
            HRESP     <= hresp_d;
        end
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        state_d     = state_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        case (state_q)
            DS_IDLE: if (accept_c) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = accept_c ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
        case (state_d)
            DS_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            DS_ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
        endcase
    end

`ifdef MFP_AHB_LITE_INTERCONNECT_ERR_LOG_EN
    logic [ERR_CNT_W-1:0] err_count_q;
    logic [ADDR_W-1:0]    err_addr_q;
    logic                 err_write_q;

    // ERR1 is always left after one cycle, so next-state ERR1 marks an entry.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else if (state_d == DS_ERR1) begin
            if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                err_count_q <= err_count_q + ERR_CNT_W'(1);
            end
            err_addr_q  <= HADDR;
            err_write_q <= HWRITE;
        end
    end

    assign ERR_COUNT = err_count_q;
    assign ERR_ADDR  = err_addr_q;
    assign ERR_WRITE = err_write_q;
`endif

endmodule

// File: rtl/mfp_ahb_lite_interconnect.sv
// AHB-Lite single-master to N-slave interconnect: table decode, data-phase mux, default slave.
// MFP_AHB_LITE_INTERCONNECT_ERR_LOG_EN adds ERR_COUNT/ERR_ADDR/ERR_WRITE outputs.
module mfp_ahb_lite_interconnect
    import mfp_ahb_lite_interconnect_pkg::*;
#(
    parameter int unsigned                   N_SLAVES  = DEF_N_SLAVES,
    parameter logic [N_SLAVES*ADDR_W-1:0]    ADDR_BASE = DEF_ADDR_BASE,
    parameter logic [N_SLAVES*ADDR_W-1:0]    ADDR_MASK = DEF_ADDR_MASK
)(
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [N_SLAVES-1:0]          HSEL_S,
    output logic                         HREADY_S,
    input  logic [N_SLAVES*DATA_W-1:0]   HRDATA_S,
    input  logic [N_SLAVES-1:0]          HREADYOUT_S,
    input  logic [N_SLAVES-1:0]          HRESP_S
`ifdef MFP_AHB_LITE_INTERCONNECT_ERR_LOG_EN
    ,
    output logic [ERR_CNT_W-1:0]         ERR_COUNT,
    output logic [ADDR_W-1:0]            ERR_ADDR,
    output logic                         ERR_WRITE
`endif
);

    if ((N_SLAVES == 0) || (N_SLAVES > MAX_SLAVES)) begin : g_bad_n_slaves
        $error("mfp_ahb_lite_interconnect: N_SLAVES must be in 1..16");
    end

    logic [N_SLAVES-1:0] hsel_c;
    logic                ds_hit_c;
    logic [N_SLAVES:0]   dsel_q;
    logic                ds_hreadyout;
    logic                ds_hresp;
    ahb_rsp_t            rsp_c;

    // Address-phase decode; the lowest matching index wins.
    always_comb begin
        hsel_c   = '0;
        ds_hit_c = 1'b1;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (ds_hit_c && addr_hit(HADDR, ADDR_BASE[i*ADDR_W +: ADDR_W],
                                     ADDR_MASK[i*ADDR_W +: ADDR_W])) begin
                hsel_c[i] = 1'b1;
                ds_hit_c  = 1'b0;
            end
        end
    end

    assign HSEL_S = hsel_c;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel_q <= '0;
        end else if (HREADY) begin
            dsel_q <= {ds_hit_c, hsel_c};
        end
    end

    // Data-phase response mux; nothing selected behaves as an always-ready OKAY.
    always_comb begin
        rsp_c = '{rdata: '0, ready: 1'b1, resp: HRESP_OKAY};
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (dsel_q[i]) begin
                rsp_c = '{rdata: HRDATA_S[i*DATA_W +: DATA_W],
                          ready: HREADYOUT_S[i],
                          resp:  HRESP_S[i]};
            end
        end
        if (dsel_q[N_SLAVES]) begin
            rsp_c = '{rdata: '0, ready: ds_hreadyout, resp: ds_hresp};
        end
    end

    assign HRDATA   = rsp_c.rdata;
    assign HREADY   = rsp_c.ready;
    assign HRESP    = rsp_c.resp;
    assign HREADY_S = rsp_c.ready;

    mfp_ahb_lite_default_slave u_ds (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .ds_sel    (ds_hit_c),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (ds_hreadyout),
        .HRESP     (ds_hresp)
`ifdef MFP_AHB_LITE_INTERCONNECT_ERR_LOG_EN
        ,
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .ERR_COUNT (ERR_COUNT),
        .ERR_ADDR  (ERR_ADDR),
        .ERR_WRITE (ERR_WRITE)
`endif
    );

`ifndef MFP_AHB_LITE_INTERCONNECT_ERR_LOG_EN
    logic unused_hwrite;
    assign unused_hwrite = HWRITE;
`endif

endmodule
